// File: rtl/iddmm_operand_loader_if.sv
// Core-side bus of the Montgomery operand loader.
// Carries the operand-RAM write port (wr_ena/wr_addr/wr_x/wr_y/wr_m),
// the held word constant wr_m1, and the task handshake
// (task_req/task_grant) plus the streamed result (task_end/task_res).
//   master : the loader (drives writes and task_req)
//   slave  : the multiplier core (drives grant and result words)
interface iddmm_operand_loader_if #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) ();
  logic [2:0]        wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_x;
  logic [K-1:0]      wr_y;
  logic [K-1:0]      wr_m;
  logic [K-1:0]      wr_m1;
  logic              task_req;
  logic              task_grant;
  logic              task_end;
  logic [K-1:0]      task_res;

  modport master (
    output wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
    input  task_grant, task_end, task_res
  );

  modport slave (
    input  wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
    output task_grant, task_end, task_res
  );
endinterface

// File: rtl/iddmm_operand_loader.sv
// Operand loader / result assembler for the Montgomery multiplier core.
// Accepts full-width x, y, m and word constant m1 on start, streams the
// selected operands LSW first into the core RAMs, requests a core task,
// then gathers the N result words back into one full-width result.
// Ports:
//   clk, rst        clock, async active-high reset
//   start, ld_mask  run request; ld_mask selects which RAMs get rewritten
//   in_x/in_y/in_m  full-width operands (word i at [i*K +: K])
//   in_m1           Montgomery word constant, forwarded on core.wr_m1
//   busy, done      run in progress / one-cycle completion pulse
//   result          assembled product, same packing as in_x
//   core            core-side write port and task handshake (master)

// One result word register; captured when its slot is addressed.
module iddmm_result_word #(
  parameter int K = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap,
  input  logic [K-1:0] din,
  output logic [K-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (cap) q <= din;
  end
endmodule

module iddmm_operand_loader #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           ld_mask,
  input  logic [K*N-1:0]       in_x,
  input  logic [K*N-1:0]       in_y,
  input  logic [K*N-1:0]       in_m,
  input  logic [K-1:0]         in_m1,
  output logic                 busy,
  output logic                 done,
  output logic [K*N-1:0]       result,
  iddmm_operand_loader_if.master core
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_DONE} state_t;

  // Latched operands. They are kept shifted so that the next word to
  // drive always sits in the low K bits; no wide word mux is needed.
  typedef struct packed {
    logic [2:0]     mask;
    logic [K*N-1:0] x;
    logic [K*N-1:0] y;
    logic [K*N-1:0] m;
  } opnd_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N-1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;     // c in LOAD, r in WAIT
  opnd_t             opnd_q, opnd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [K-1:0]      wr_x_q, wr_x_d;
  logic [K-1:0]      wr_y_q, wr_y_d;
  logic [K-1:0]      wr_m_q, wr_m_d;
  logic [K-1:0]      wr_m1_q, wr_m1_d;
  logic              task_req_q, task_req_d;

  // All registered outputs are computed one cycle ahead from the
  // transition being taken, so the first write is visible right after
  // start and task_req right after the last write.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wr_ena_d   = 3'b000;
    wr_addr_d  = wr_addr_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_m_d     = wr_m_q;
    wr_m1_d    = wr_m1_q;
    task_req_d = task_req_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opnd_d.mask = ld_mask;
          opnd_d.x    = in_x >> K;
          opnd_d.y    = in_y >> K;
          opnd_d.m    = in_m >> K;
          wr_m1_d     = in_m1;
          cnt_d       = '0;
          busy_d      = 1'b1;
          if (ld_mask != 3'b000) begin
            state_d   = S_LOAD;
            wr_ena_d  = ld_mask;
            wr_addr_d = '0;
            wr_x_d    = in_x[K-1:0];
            wr_y_d    = in_y[K-1:0];
            wr_m_d    = in_m[K-1:0];
          end else begin
            state_d    = S_REQ;
            task_req_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // cnt_q is the word currently on the bus
        if (cnt_q == LAST) begin
          state_d    = S_REQ;
          cnt_d      = '0;
          task_req_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          wr_ena_d  = opnd_q.mask;
          wr_addr_d = cnt_q + 1'b1;
          wr_x_d    = opnd_q.x[K-1:0];
          wr_y_d    = opnd_q.y[K-1:0];
          wr_m_d    = opnd_q.m[K-1:0];
          opnd_d.x  = opnd_q.x >> K;
          opnd_d.y  = opnd_q.y >> K;
          opnd_d.m  = opnd_q.m >> K;
        end
      end
      S_REQ: begin
        if (core.task_grant) begin
          state_d    = S_WAIT;
          cnt_d      = '0;
          task_req_d = 1'b0;
        end
      end
      S_WAIT: begin
        // word capture itself lives in the result word array below
        if (core.task_end) begin
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opnd_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ena_q   <= 3'b000;
      wr_addr_q  <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_m_q     <= '0;
      wr_m1_q    <= '0;
      task_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ena_q   <= wr_ena_d;
      wr_addr_q  <= wr_addr_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_m_q     <= wr_m_d;
      wr_m1_q    <= wr_m1_d;
      task_req_q <= task_req_d;
    end
  end

  // Result assembly: one register per word, enabled by the word slot.
  logic [N-1:0]        cap_en;
  logic [N-1:0][K-1:0] res_words;

  for (genvar w = 0; w < N; w++) begin : g_res
    assign cap_en[w] = (state_q == S_WAIT) && core.task_end &&
                       (cnt_q == ADDR_W'(w));
    iddmm_result_word #(.K(K)) u_word (
      .clk (clk),
      .rst (rst),
      .cap (cap_en[w]),
      .din (core.task_res),
      .q   (res_words[w])
    );
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = res_words;
  assign core.wr_ena   = wr_ena_q;
  assign core.wr_addr  = wr_addr_q;
  assign core.wr_x     = wr_x_q;
  assign core.wr_y     = wr_y_q;
  assign core.wr_m     = wr_m_q;
  assign core.wr_m1    = wr_m1_q;
  assign core.task_req = task_req_q;

endmodule

// File: tb/tb_iddmm_operand_loader.sv
// Bench for iddmm_operand_loader (K=8, N=4). Acts as the multiplier core:
// keeps its own operand RAM images written from the DUT's write port,
// and a reference of what those RAMs and the result should hold.
module tb_iddmm_operand_loader;
  localparam int K  = 8;
  localparam int N  = 4;
  localparam int AW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2:0]     ld_mask;
  logic [K*N-1:0] in_x, in_y, in_m;
  logic [K-1:0]   in_m1;
  logic           busy, done;
  logic [K*N-1:0] result;

  iddmm_operand_loader_if #(.K(K), .N(N), .ADDR_W(AW)) core_if ();

  iddmm_operand_loader #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ld_mask (ld_mask),
    .in_x    (in_x),
    .in_y    (in_y),
    .in_m    (in_m),
    .in_m1   (in_m1),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .core    (core_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // core RAM images (written from the DUT write port)
  logic [K-1:0] cx [N];
  logic [K-1:0] cy [N];
  logic [K-1:0] cm [N];
  // reference: full operand each RAM must hold, and which are defined
  logic [K*N-1:0] mx, my, mm, exp_res;
  logic [2:0]     ram_ok;
  logic [K-1:0]   exp_m1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [K-1:0] word_of(input logic [K*N-1:0] v, input int i);
    return K'((v >> (i*K)) & {{(K*N-K){1'b0}}, {K{1'b1}}});
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(busy), 0);
    chk({tag, "_done"},  64'(done), 0);
    chk({tag, "_res"},   64'(result), 0);
    chk({tag, "_ena"},   64'(core_if.wr_ena), 0);
    chk({tag, "_addr"},  64'(core_if.wr_addr), 0);
    chk({tag, "_wx"},    64'(core_if.wr_x), 0);
    chk({tag, "_wy"},    64'(core_if.wr_y), 0);
    chk({tag, "_wm"},    64'(core_if.wr_m), 0);
    chk({tag, "_wm1"},   64'(core_if.wr_m1), 0);
    chk({tag, "_req"},   64'(core_if.task_req), 0);
  endtask

  task automatic capture();
    if (core_if.wr_ena[0]) cx[core_if.wr_addr] = core_if.wr_x;
    if (core_if.wr_ena[1]) cy[core_if.wr_addr] = core_if.wr_y;
    if (core_if.wr_ena[2]) cm[core_if.wr_addr] = core_if.wr_m;
  endtask

  // One full run. abort_at>0 asserts reset after that many result words.
  task automatic run(input logic [2:0] mask, input logic [K*N-1:0] x, y, m,
                     input logic [K-1:0] m1, input int gdly,
                     input logic [K*N-1:0] res, input logic [N-1:0][1:0] gaps,
                     input bit noise, input int abort_at);
    start = 1'b1; ld_mask = mask; in_x = x; in_y = y; in_m = m; in_m1 = m1;
    step();
    start = 1'b0;
    if (mask[0]) mx = x;
    if (mask[1]) my = y;
    if (mask[2]) mm = m;
    ram_ok |= mask;
    exp_m1 = m1;
    chk("busy_after_start", 64'(busy), 1);
    chk("m1_after_start", 64'(core_if.wr_m1), 64'(exp_m1));
    if (mask != 3'b000) begin
      for (int i = 0; i < N; i++) begin
        chk("ld_ena",  64'(core_if.wr_ena), 64'(mask));
        chk("ld_addr", 64'(core_if.wr_addr), 64'(i));
        chk("ld_x",    64'(core_if.wr_x), 64'(word_of(x, i)));
        chk("ld_y",    64'(core_if.wr_y), 64'(word_of(y, i)));
        chk("ld_m",    64'(core_if.wr_m), 64'(word_of(m, i)));
        chk("ld_req",  64'(core_if.task_req), 0);
        capture();
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          ld_mask = 3'($urandom_range(0, 7));
          in_x = $urandom; in_y = $urandom; in_m = $urandom; in_m1 = 8'($urandom);
          core_if.task_grant = 1'($urandom_range(0, 1));
          core_if.task_end = 1'($urandom_range(0, 1));
          core_if.task_res = 8'($urandom);
        end
        step();
      end
      start = 1'b0; core_if.task_grant = 1'b0; core_if.task_end = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (ram_ok[0]) chk("ram_x", 64'(cx[i]), 64'(word_of(mx, i)));
      if (ram_ok[1]) chk("ram_y", 64'(cy[i]), 64'(word_of(my, i)));
      if (ram_ok[2]) chk("ram_m", 64'(cm[i]), 64'(word_of(mm, i)));
    end
    for (int j = 0; j <= gdly; j++) begin
      chk("req_high", 64'(core_if.task_req), 1);
      chk("req_noena", 64'(core_if.wr_ena), 0);
      chk("req_busy", 64'(busy), 1);
      if (j == gdly) core_if.task_grant = 1'b1;
      else if (noise) start = 1'($urandom_range(0, 1));
      step();
      start = 1'b0;
    end
    core_if.task_grant = 1'b0;
    chk("req_dropped", 64'(core_if.task_req), 0);
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < int'(gaps[k]); g++) begin
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          core_if.task_grant = 1'($urandom_range(0, 1));
        end
        step();
        start = 1'b0; core_if.task_grant = 1'b0;
        chk("gap_done", 64'(done), 0);
        chk("gap_busy", 64'(busy), 1);
      end
      core_if.task_end = 1'b1; core_if.task_res = word_of(res, k);
      step();
      core_if.task_end = 1'b0; core_if.task_res = 8'($urandom);
      if (k < N-1) begin
        chk("word_done", 64'(done), 0);
        chk("word_busy", 64'(busy), 1);
        if (abort_at == k+1) begin
          rst = 1'b1;
          #1;
          chk_all_zero("abort");
          exp_res = '0; ram_ok = 3'b000;
          step();
          rst = 1'b0;
          step();
          return;
        end
      end
    end
    exp_res = res;
    chk("done_pulse", 64'(done), 1);
    chk("done_busy", 64'(busy), 0);
    chk("done_req", 64'(core_if.task_req), 0);
    chk("result", 64'(result), 64'(exp_res));
    chk("m1_held", 64'(core_if.wr_m1), 64'(exp_m1));
    start = 1'b1;                 // dropped in DONE
    step();
    start = 1'b0;
    chk("done_single", 64'(done), 0);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_result", 64'(result), 64'(exp_res));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld_mask = '0;
    in_x = '0; in_y = '0; in_m = '0; in_m1 = '0;
    core_if.task_grant = 1'b0; core_if.task_end = 1'b0; core_if.task_res = '0;
    mx = '0; my = '0; mm = '0; exp_res = '0; ram_ok = 3'b000; exp_m1 = '0;
    for (int i = 0; i < N; i++) begin cx[i] = '0; cy[i] = '0; cm[i] = '0; end
    #1;
    chk_all_zero("reset");
    step(); step();
    rst = 1'b0;
    step();
    chk_all_zero("post_reset");

    // directed: full load, grant after 3 cycles, words with gaps 0,2,1
    run(3'b111, 32'h04030201, 32'h14131211, 32'h24232221, 8'h5A, 3,
        32'hDDCCBBAA, {2'd1, 2'd2, 2'd0, 2'd0}, 1'b0, 0);
    // reload x,y only with new m1; m RAM must keep its old image
    run(3'b011, 32'h44332211, 32'h88776655, 32'hFFFFFFFF, 8'hC3, 0,
        32'h01020304, {2'd0, 2'd1, 2'd0, 2'd2}, 1'b0, 0);
    // no reload: straight to REQ
    run(3'b000, 32'h0, 32'h0, 32'h0, 8'h11, 1,
        32'h55AA55AA, {2'd0, 2'd0, 2'd0, 2'd0}, 1'b0, 0);

    // stray task_end in IDLE must not touch result
    core_if.task_end = 1'b1; core_if.task_res = 8'h77;
    step();
    core_if.task_end = 1'b0;
    step();
    chk("idle_task_end", 64'(result), 64'(exp_res));

    // randomized runs with ignored-input noise
    for (int r = 0; r < 8; r++) begin
      run(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 8'($urandom),
          $urandom_range(0, 3), $urandom, 8'($urandom), 1'b1, 0);
      repeat ($urandom_range(0, 2)) step();
    end

    // reset mid-WAIT after 2 words, then a clean run
    run(3'b111, $urandom, $urandom, $urandom, 8'($urandom), 1,
        $urandom, {2'd0, 2'd1, 2'd0, 2'd1}, 1'b1, 2);
    run(3'b111, $urandom, $urandom, $urandom, 8'($urandom), 2,
        $urandom, 8'($urandom), 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
